// File: rtl/fp32_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp32_addsub_arbiter
// Description : Shares one pipelined FP32 add/sub unit between NREQ
//               requesters. A round-robin arbiter picks one request per
//               cycle and registers it onto the adder operand port. Subtract
//               is performed by flipping the sign of operand B. A LATENCY-deep
//               tag pipe follows each issued operation, and the returning
//               result is steered back to the requester that issued it.
//               A sticky flag records any issue/return misalignment.
// Ports       : clk, rstn (sync, active-high)
//               req_valid/req_ready/req_a/req_b/req_sub : requester side
//               add_valid_in/add_a/add_b                : adder issue port
//               add_valid_out/add_result                : adder return port
//               res_valid/res_data                      : result return
//               busy, err_align                         : status
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_addsub_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 4,
    parameter int TAGW    = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic                 add_valid_in,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    input  logic                 add_valid_out,
    input  logic [31:0]          add_result,
    output logic [NREQ-1:0]      res_valid,
    output logic [31:0]          res_data,
    output logic                 busy,
    output logic                 err_align
);

    // One extra bit so ptr + offset never overflows before the modulo fold.
    localparam int c_sum_w = TAGW + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TAGW-1:0]    ptr_q,        ptr_d;
    logic               issue_vld_q,  issue_vld_d;
    logic [TAGW-1:0]    issue_tag_q,  issue_tag_d;
    logic [31:0]        add_a_q,      add_a_d;
    logic [31:0]        add_b_q,      add_b_d;
    logic [LATENCY-1:0] pipe_vld_q;
    logic [TAGW-1:0]    pipe_tag_q [LATENCY];
    logic [NREQ-1:0]    res_valid_q,  res_valid_d;
    logic [31:0]        res_data_q,   res_data_d;
    logic               err_q,        err_d;

    // ------------------------------------------------------------------
    // Round-robin search: rotate the request vector so that bit 0 is the
    // requester at ptr, find the first set bit, then rotate the offset back.
    // ------------------------------------------------------------------
    logic [2*NREQ-1:0]  w_dbl;
    logic [NREQ-1:0]    w_rot;
    logic [c_sum_w-1:0] w_off;
    logic [c_sum_w-1:0] w_sum;
    logic               w_found;
    logic               w_grant;
    logic [TAGW-1:0]    w_win;
    logic [NREQ-1:0]    w_ready;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic               w_sel_sub;

    assign w_dbl = {req_valid, req_valid} >> ptr_q;
    assign w_rot = w_dbl[NREQ-1:0];

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = c_sum_w'(i);
            end
        end
    end

    assign w_sum   = {1'b0, ptr_q} + w_off;
    assign w_win   = (w_sum >= c_sum_w'(NREQ)) ? TAGW'(w_sum - c_sum_w'(NREQ))
                                               : w_sum[TAGW-1:0];
    // No grants while reset is held, so nothing is issued into a pipe that
    // is being cleared.
    assign w_grant = w_found & ~rstn;

    always_comb begin
        w_ready = '0;
        if (w_grant) begin
            w_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == TAGW'(i)) begin
                w_sel_a   = req_a[i*32 +: 32];
                w_sel_b   = req_b[i*32 +: 32];
                w_sel_sub = req_sub[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Return path: the oldest tag-pipe entry lines up with add_valid_out.
    // ------------------------------------------------------------------
    logic            w_head_vld;
    logic [TAGW-1:0] w_head_tag;
    logic            w_fire;

    assign w_head_vld = pipe_vld_q[LATENCY-1];
    assign w_head_tag = pipe_tag_q[LATENCY-1];
    assign w_fire     = add_valid_out & w_head_vld;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d       = ptr_q;
        issue_vld_d = w_grant;
        issue_tag_d = issue_tag_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        if (w_grant) begin
            ptr_d       = (w_win == TAGW'(NREQ-1)) ? '0 : w_win + TAGW'(1);
            issue_tag_d = w_win;
            add_a_d     = w_sel_a;
            // Subtraction is addition with B's sign flipped.
            add_b_d     = {w_sel_b[31] ^ w_sel_sub, w_sel_b[30:0]};
        end

        res_valid_d = '0;
        res_data_d  = res_data_q;
        if (w_fire) begin
            res_valid_d[w_head_tag] = 1'b1;
            res_data_d              = add_result;
        end

        // A result without a tag, or a tag without a result, is a misalignment.
        err_d = err_q | (add_valid_out ^ w_head_vld);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            ptr_q       <= '0;
            issue_vld_q <= 1'b0;
            issue_tag_q <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            pipe_vld_q  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
            end
            res_valid_q <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            issue_vld_q <= issue_vld_d;
            issue_tag_q <= issue_tag_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            // Entry 0 is written while the adder samples the issue register,
            // so entry LATENCY-1 is valid exactly when add_valid_out arrives.
            pipe_vld_q[0] <= issue_vld_q;
            pipe_tag_q[0] <= issue_tag_q;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready    = w_ready;
    assign add_valid_in = issue_vld_q;
    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign busy         = (|pipe_vld_q) | issue_vld_q;
    assign err_align    = err_q;

endmodule
`default_nettype wire

// File: doc/fp32_addsub_arbiter.md
Name: fp32_addsub_arbiter

Overview:
- Shares one pipelined FP32 add/sub unit between NREQ requesters.
- Selects one request per cycle by round-robin and drives the unit's operand port.
- Tracks each issued operation with a LATENCY-deep tag shift register and routes the unit's result back to the requester that issued it.
- Sits between the layer compute controllers and the shared adder. A sticky error flags any issue/return misalignment.

Parameters:
NREQ, 4, number of requesters (2..8)
LATENCY, 4, clock cycles from adder valid_in to valid_out (>=1); fixed by the adder instance
TAGW, 2, tag width, equal to clog2(NREQ)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous reset, active-high (asserted = 1 clears state on next clk edge)
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant; a transfer occurs when valid & ready
req_a  in  NREQ*32  operand A per requester, FP32
req_b  in  NREQ*32  operand B per requester, FP32
req_sub  in  NREQ  1 = A-B, 0 = A+B
add_valid_in  out  1  issue strobe to shared adder
add_a  out  32  operand A to adder
add_b  out  32  operand B to adder; sign bit inverted when req_sub = 1
add_valid_out  in  1  result strobe from adder
add_result  in  32  FP32 result from adder
res_valid  out  NREQ  one-hot result strobe, one cycle per returned result
res_data  out  32  result data, shared bus, meaningful only with res_valid
busy  out  1  1 while any tag is in flight
err_align  out  1  sticky error flag

Behaviour:
- Reset: req_ready=0, add_valid_in=0, add_a=0, add_b=0, res_valid=0, res_data=0, busy=0, err_align=0. Tag pipe cleared, RR pointer=0.
  - Reset mid-operation discards all in-flight tags.
  - Adder results arriving afterwards with no tag set err_align, unless rstn is still asserted that cycle.
- Arbitration (combinational in cycle t, registered issue at t+1):
  - Search starts at index ptr and wraps modulo NREQ; the first index with req_valid=1 wins.
  - req_ready is one-hot on the winner and zero elsewhere. No request valid means req_ready=0.
  - On a grant, ptr <= winner+1 mod NREQ. With no grant, ptr holds.
- Issue register: on a grant, next cycle add_valid_in=1, add_a=req_a[w], add_b={req_b[w][31]^req_sub[w], req_b[w][30:0]}. Otherwise add_valid_in=0 and operands hold.
- Throughput: one issue per cycle; requesters are never stalled by the adder.
- Tag pipe:
  - LATENCY entries of {vld, tag}. Entry 0 loads {add_valid_in, winner tag} on the same edge the issue register loads.
  - Entries shift every cycle. The head entry lines up with add_valid_out for the same operation.
- Return: a registered stage, so total request-to-result latency is LATENCY+2 cycles.
  - When add_valid_out=1 and head.vld=1: res_valid[head.tag]=1 and res_data=add_result on the next cycle.
  - res_data holds its value otherwise.
- Alignment check:
  - add_valid_out != head.vld sets err_align=1. It stays set until rstn.
  - On a spurious add_valid_out, no res_valid is produced.
- busy = OR of all tag-pipe vld bits, OR add_valid_in.
- Requester contract:
  - req_a, req_b and req_sub must be stable while req_valid=1 and req_ready=0.
  - Results have no backpressure; the requester must sink res_valid.

Test Plan:
- Single request, LATENCY=4: req_valid=0001, A=0x3F800000, B=0x40000000, sub=0, at t0 -> req_ready[0]=1 at t0; add_valid_in at t1 with add_b=0x40000000; model adder returns 0x40400000 at t5 -> res_valid=0001, res_data=0x40400000 at t6.
- Subtract: requester 2, A=0x40400000, B=0x3F800000, sub=1 -> add_b=0xBF800000; result 0x40000000 on res_valid=0100.
- Round-robin fairness: all four valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; results return in the same order with matching tags; each requester receives exactly 2 results.
- Wrap and skip: ptr=3, req_valid=0101 -> grant 0, then 2, then 0; requesters 1 and 3 are never granted.
- Back-to-back with gaps: issue pattern 1,0,1,1 -> res_valid pattern repeats LATENCY+1 cycles later; busy falls 1 cycle after the last vld leaves the pipe.
- Errors and reset: inject add_valid_out with the tag pipe empty -> err_align=1, res_valid=0; assert rstn for 1 cycle mid-flight -> all outputs zero next cycle; err_align clears and later stray results set it again.
